// File: rtl/palram_mixer_if.sv
// Bus bundle for the palette mixer: video layer inputs, CPU request/ack port,
// DMA write port, clear control and the colour/status outputs.
interface palram_mixer_if #(
  parameter int NUM_PF  = 3,
  parameter int COLOR_W = 11,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 16
);
  // Video side
  logic                        ce_pix;
  logic [ADDR_W-COLOR_W-1:0]   bank;
  logic [NUM_PF*COLOR_W-1:0]   pf_color;
  logic [NUM_PF-1:0]           pf_opaque;
  logic [NUM_PF-1:0]           pf_prio;
  logic [COLOR_W-1:0]          obj_color;
  logic                        obj_active;
  logic [DATA_W-1:0]           rgb_out;
  // CPU side
  logic                        cpu_req;
  logic                        cpu_we;
  logic [ADDR_W-1:0]           cpu_addr;
  logic [DATA_W-1:0]           cpu_din;
  logic                        cpu_ack;
  logic [DATA_W-1:0]           cpu_dout;
  // DMA and clear engine
  logic                        dma_we;
  logic [ADDR_W-1:0]           dma_addr;
  logic [DATA_W-1:0]           dma_din;
  logic                        clear_start;
  logic                        busy;

  modport master (
    output ce_pix, bank, pf_color, pf_opaque, pf_prio, obj_color, obj_active,
           cpu_req, cpu_we, cpu_addr, cpu_din, dma_we, dma_addr, dma_din, clear_start,
    input  rgb_out, cpu_ack, cpu_dout, busy
  );

  modport slave (
    input  ce_pix, bank, pf_color, pf_opaque, pf_prio, obj_color, obj_active,
           cpu_req, cpu_we, cpu_addr, cpu_din, dma_we, dma_addr, dma_din, clear_start,
    output rgb_out, cpu_ack, cpu_dout, busy
  );
endinterface

// File: rtl/palram_mixer.sv
// Palette mixer: resolves NUM_PF playfields plus the object layer into one
// palette index, looks it up in a single-port palette RAM and outputs RGB.
// The RAM port is shared per clock between the clear engine, DMA, the video
// lookup and the CPU, in that priority order.
module palram_mixer #(
  parameter int NUM_PF  = 3,
  parameter int COLOR_W = 11,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 16
) (
  input logic             clk,
  input logic             reset,
  palram_mixer_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} clr_state_e;

  clr_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;

  logic [COLOR_W-1:0]  top_color, win_color;
  logic                top_valid, top_prio;
  logic [ADDR_W-1:0]   s1_addr_q;
  logic                vid_slot_q;
  logic [DATA_W-1:0]   s2_data_q, rgb_q;
  logic                cpu_ack_q, dma_tail_q;
  logic [DATA_W-1:0]   cpu_dout_q;

  logic                dma_eff, busy, vid_read, cpu_grant;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Layer resolve: topmost opaque playfield, then object-vs-playfield priority.
  // NOTE: every always_comb output gets a default first so no path can infer a latch;
  // blocking '=' is used here because later statements read earlier results.
  always_comb begin
    top_valid = 1'b0;
    top_prio  = 1'b0;
    top_color = '0;
    for (int k = 0; k < NUM_PF; k++) begin
      if (bus.pf_opaque[k]) begin
        top_valid = 1'b1;
        top_prio  = bus.pf_prio[k];
        top_color = bus.pf_color[k*COLOR_W +: COLOR_W];
      end
    end
    win_color = (bus.obj_active && !(top_valid && top_prio)) ? bus.obj_color : top_color;
  end

  // Clear FSM next state: sweep every address once, then one DONE cycle.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.clear_start) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == {ADDR_W{1'b1}}) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Clear FSM state register; reset abandons a sweep in progress.
  // NOTE: sequential state uses non-blocking '<=' so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // DMA is dropped during a sweep and in the cycle a sweep is launched.
  assign dma_eff = bus.dma_we && (state_q != ST_CLEAR) &&
                   !((state_q == ST_IDLE) && bus.clear_start);
  assign busy    = dma_eff || dma_tail_q || (state_q != ST_IDLE);

  // RAM port arbitration: clear > DMA > video slot > CPU.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = bus.cpu_addr;
    ram_wdata = bus.cpu_din;
    vid_read  = 1'b0;
    cpu_grant = 1'b0;
    if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_addr_q;
      ram_wdata = '0;
    end else if (dma_eff) begin
      ram_we    = 1'b1;
      ram_addr  = bus.dma_addr;
      ram_wdata = bus.dma_din;
    end else if (vid_slot_q) begin
      ram_addr  = s1_addr_q;
      vid_read  = 1'b1;
    end else if (bus.cpu_req && !cpu_ack_q) begin
      // The ack cycle still sees the old request, so it cannot start a new one.
      cpu_grant = 1'b1;
      ram_we    = bus.cpu_we;
    end
  end

  // Palette RAM: synchronous write, asynchronous read.
  // NOTE: the memory array has no reset; contents survive reset and are only
  // zeroed by the clear engine.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr];

  // Video pipeline: S1 address on ce_pix, RAM read next cycle, rgb on following ce_pix.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_addr_q  <= '0;
      vid_slot_q <= 1'b0;
      s2_data_q  <= '0;
      rgb_q      <= '0;
    end else begin
      vid_slot_q <= bus.ce_pix;
      if (bus.ce_pix) s1_addr_q <= {bus.bank, win_color};
      if (vid_read)   s2_data_q <= ram_rdata;
      if (bus.ce_pix) rgb_q <= busy     ? '0        :
                               vid_read ? ram_rdata : s2_data_q;
    end
  end

  // CPU completion and DMA busy tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_ack_q  <= 1'b0;
      cpu_dout_q <= '0;
      dma_tail_q <= 1'b0;
    end else begin
      cpu_ack_q  <= cpu_grant;
      dma_tail_q <= dma_eff;
      if (cpu_grant && !bus.cpu_we) cpu_dout_q <= ram_rdata;
    end
  end

  assign bus.rgb_out  = rgb_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.cpu_dout = cpu_dout_q;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_palram_mixer.sv
// Directed bench for palram_mixer: layer resolve, video latency, CPU port,
// clear engine, DMA priority over CPU and reset during a clear sweep.
module tb_palram_mixer;

  localparam int NUM_PF  = 3;
  localparam int COLOR_W = 11;
  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 16;

  logic clk = 1'b0;
  logic reset;
  logic ce_auto = 1'b0;
  logic ce_man  = 1'b0;
  logic ce_tick = 1'b0;
  int   ce_cnt  = 0;
  int   checks  = 0;
  int   errors  = 0;

  palram_mixer_if #(.NUM_PF(NUM_PF), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  palram_mixer #(.NUM_PF(NUM_PF), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // ce_pix either manual or one pulse every fourth clock
  assign bus.ce_pix = ce_auto ? ce_tick : ce_man;
  always @(posedge clk) begin
    #1;
    ce_tick = (ce_cnt == 3);
    ce_cnt  = (ce_cnt + 1) % 4;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dma_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.dma_we   = 1'b1;
    bus.dma_addr = a;
    bus.dma_din  = d;
    tick();
    bus.dma_we   = 1'b0;
  endtask

  // One CPU transaction; reports cycles to ack and whether it timed out
  task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            output logic [DATA_W-1:0] dout, output int cycles, output bit timed_out);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = we;
    bus.cpu_addr = a;
    bus.cpu_din  = d;
    cycles    = 0;
    timed_out = 1'b0;
    dout      = '0;
    forever begin
      tick();
      cycles++;
      if (bus.cpu_ack) begin
        dout = bus.cpu_dout;
        break;
      end
      if (cycles >= 20) begin
        timed_out = 1'b1;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
  endtask

  // Read one word and compare it, used for memory readback
  task automatic read_expect(input string name, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    logic [DATA_W-1:0] d;
    int  c;
    bit  to;
    cpu_access(1'b0, a, '0, d, c, to);
    check({name, " timeout"}, to, 1'b0);
    check(name, d, exp);
  endtask

  task automatic set_pixel(input logic [2:0] op, input logic [2:0] pr, input logic oa);
    bus.bank       = 2'b01;
    bus.pf_color   = {11'h033, 11'h022, 11'h011};
    bus.pf_opaque  = op;
    bus.pf_prio    = pr;
    bus.obj_color  = 11'h123;
    bus.obj_active = oa;
  endtask

  // Two manual ce_pix pulses; returns rgb after the first and after the second
  task automatic pixel_cycle(output logic [DATA_W-1:0] after_first, output logic [DATA_W-1:0] after_second);
    ce_man = 1'b1;
    tick();
    ce_man = 1'b0;
    tick();
    after_first = bus.rgb_out;
    ce_man = 1'b1;
    tick();
    ce_man = 1'b0;
    after_second = bus.rgb_out;
    tick();
  endtask

  task automatic test_reset_seq();
    reset            = 1'b1;
    bus.cpu_req      = 1'b0;
    bus.cpu_we       = 1'b0;
    bus.cpu_addr     = '0;
    bus.cpu_din      = '0;
    bus.dma_we       = 1'b0;
    bus.dma_addr     = '0;
    bus.dma_din      = '0;
    bus.clear_start  = 1'b0;
    set_pixel(3'b000, 3'b000, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset busy", bus.busy, 1'b0);
    check("reset rgb_out", bus.rgb_out, 16'h0000);
    check("reset cpu_ack", bus.cpu_ack, 1'b0);
  endtask

  task automatic test_layer_resolve();
    logic [DATA_W-1:0] r1, r2;
    dma_write(13'h0923, 16'hA5A5);
    dma_write(13'h0833, 16'h3333);
    dma_write(13'h0800, 16'h1111);
    tick();
    tick();
    set_pixel(3'b101, 3'b000, 1'b1);
    pixel_cycle(r1, r2);
    check("obj over non-prio playfield", r2, 16'hA5A5);
    set_pixel(3'b101, 3'b100, 1'b1);
    pixel_cycle(r1, r2);
    check("prio playfield over obj", r2, 16'h3333);
    set_pixel(3'b000, 3'b000, 1'b0);
    pixel_cycle(r1, r2);
    check("backdrop", r2, 16'h1111);
  endtask

  task automatic test_latency();
    logic [DATA_W-1:0] r1, r2;
    set_pixel(3'b101, 3'b000, 1'b1);
    pixel_cycle(r1, r2);
    check("latency: old pixel after 1 ce_pix", r1, 16'h1111);
    check("latency: new pixel after 2 ce_pix", r2, 16'hA5A5);
  endtask

  task automatic test_cpu();
    logic [DATA_W-1:0] d;
    int  c;
    bit  to;
    ce_auto = 1'b1;
    cpu_access(1'b1, 13'h0400, 16'h7FFF, d, c, to);
    check("cpu write timeout", to, 1'b0);
    check("cpu write ack within 2 clk", (c <= 2), 1'b1);
    tick();
    check("cpu no duplicate ack", bus.cpu_ack, 1'b0);
    cpu_access(1'b0, 13'h0400, '0, d, c, to);
    check("cpu read timeout", to, 1'b0);
    check("cpu read ack within 2 clk", (c <= 2), 1'b1);
    check("cpu read data", d, 16'h7FFF);
  endtask

  task automatic test_clear();
    int busy_cnt;
    int viol;
    ce_auto = 1'b1;
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    busy_cnt = 0;
    viol     = 0;
    while (bus.busy && busy_cnt < 10000) begin
      busy_cnt++;
      if (busy_cnt > 4 && bus.rgb_out !== 16'h0000) viol++;
      tick();
    end
    check("clear busy length", busy_cnt, (2 ** ADDR_W) + 1);
    check("rgb blanked while busy", viol, 0);
    read_expect("clear 0x0923", 13'h0923, 16'h0000);
    read_expect("clear 0x0400", 13'h0400, 16'h0000);
    read_expect("clear 0x0000", 13'h0000, 16'h0000);
    read_expect("clear 0x1FFF", 13'h1FFF, 16'h0000);
  endtask

  task automatic test_dma_burst();
    int ack_burst;
    int ack_total;
    ce_auto   = 1'b0;
    ack_burst = 0;
    ack_total = 0;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 13'h0500;
    bus.cpu_din  = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
      bus.dma_we   = 1'b1;
      bus.dma_addr = 13'h0600 + i;
      bus.dma_din  = 16'hD000 + i;
      tick();
      if (bus.cpu_ack) ack_burst++;
    end
    bus.dma_we = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.cpu_ack) begin
        ack_total++;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
      end
    end
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    check("no cpu ack during dma burst", ack_burst, 0);
    check("exactly one cpu ack after burst", ack_total, 1);
    read_expect("dma word 0", 13'h0600, 16'hD000);
    read_expect("dma word 15", 13'h060F, 16'hD00F);
    read_expect("cpu write after burst", 13'h0500, 16'hBEEF);
  endtask

  task automatic test_reset_mid_clear();
    ce_auto = 1'b0;
    dma_write(13'h07FF, 16'h4444);
    dma_write(13'h0800, 16'h5555);
    dma_write(13'h0801, 16'h6666);
    dma_write(13'h1FFF, 16'h7777);
    tick();
    tick();
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    for (int i = 0; i < 13'h0800; i++) tick();
    check("clear reached 0x0800", dut.clr_addr_q, 13'h0800);
    reset = 1'b1;
    #1;
    check("busy low on reset mid-clear", bus.busy, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("busy low after reset release", bus.busy, 1'b0);
    read_expect("cleared below 0x0800", 13'h07FF, 16'h0000);
    read_expect("kept 0x0800", 13'h0800, 16'h5555);
    read_expect("kept 0x0801", 13'h0801, 16'h6666);
    read_expect("kept 0x1FFF", 13'h1FFF, 16'h7777);
  endtask

  initial begin
    test_reset_seq();
    test_layer_resolve();
    test_latency();
    test_cpu();
    test_clear();
    test_dma_burst();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
